// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, terminator default and
// ASCII command bytes also used by the RX command detector.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      WAIT_DONE = 3'd2,
`ifdef UART_TERM_EN
      TERM      = 3'd3,
`endif
      GAP       = 3'd4
   } state_t;

   localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h23;

   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_HASH = 8'h23;
   localparam logic [7:0] ASCII_S    = 8'h53;
   localparam logic [7:0] ASCII_R    = 8'h52;
   localparam logic [7:0] ASCII_A    = 8'h41;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr (wrapping),
// returned one-hot.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   // Walk offsets from farthest to nearest so the nearest set bit wins last.
   always_comb begin
      grant = '0;
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (((32'(ptr) + k - 1) % NUM_REQ) == j)) begin
               grant = NUM_REQ'(1) << j;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ message sources.
// Define UART_TERM_EN to append TERM_CHAR after every completed message.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned GAP_CYCLES = 16
`ifdef UART_TERM_EN
   ,
   parameter logic [7:0]  TERM_CHAR  = TERM_CHAR_DEFAULT
`endif
) (
   input  logic                   clk_50M,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     byte_ack,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_done,
   output logic                   busy
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   state_t               state;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     owner;
   logic [PTR_W-1:0]     win_idx;
   logic [PTR_W-1:0]     sel_idx;
   logic [PTR_W-1:0]     next_ptr;
   logic [GAP_W-1:0]     gap_cnt;
   logic                 last_flag;
   logic [NUM_REQ-1:0]   arb_grant;
   logic [7:0]           sel_data;
   logic                 sel_last;
   logic                 sel_req;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (arb_grant)
   );

   always_comb begin
      win_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (arb_grant[k]) win_idx = PTR_W'(k);
      end
   end

   assign sel_idx  = (state == IDLE) ? win_idx : owner;
   assign next_ptr = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      sel_req  = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (PTR_W'(k) == sel_idx) begin
            sel_data = req_data[8*k +: 8];
            sel_last = req_last[k];
            sel_req  = req[k];
         end
      end
   end

   // Byte capture, tx_start and byte_ack are registered on the edge entering
   // LOAD, so they are visible for exactly the one LOAD cycle.
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         byte_ack  <= '0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         busy      <= 1'b0;
         rr_ptr    <= '0;
         owner     <= '0;
         gap_cnt   <= '0;
         last_flag <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         byte_ack <= '0;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  grant     <= arb_grant;
                  owner     <= win_idx;
                  tx_data   <= sel_data;
                  last_flag <= sel_last;
                  tx_start  <= 1'b1;
                  byte_ack  <= arb_grant;
                  busy      <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: state <= WAIT_DONE;
            WAIT_DONE: begin
               if (tx_done) begin
                  if (!last_flag && sel_req) begin
                     tx_data   <= sel_data;
                     last_flag <= sel_last;
                     tx_start  <= 1'b1;
                     byte_ack  <= grant;
                     state     <= LOAD;
`ifdef UART_TERM_EN
                  end else if (last_flag) begin
                     tx_data  <= TERM_CHAR;
                     tx_start <= 1'b1;
                     state    <= TERM;
`endif
                  end else begin
                     grant   <= '0;
                     rr_ptr  <= next_ptr;
                     gap_cnt <= '0;
                     state   <= GAP;
                  end
               end
            end
`ifdef UART_TERM_EN
            TERM: begin
               if (tx_done) begin
                  grant   <= '0;
                  rr_ptr  <= next_ptr;
                  gap_cnt <= '0;
                  state   <= GAP;
               end
            end
`endif
            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  gap_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: cycle table plus message-level sequences.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

   localparam int unsigned NUM_REQ    = 3;
   localparam int unsigned GAP_CYCLES = 16;
`ifdef UART_TERM_EN
   localparam int TE = 1;
`else
   localparam int TE = 0;
`endif

   logic                 clk_50M = 1'b0;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   byte_ack;
   logic [7:0]           tx_data;
   logic                 tx_start;
   logic                 tx_done;
   logic                 busy;

   uart_tx_scheduler #(
      .NUM_REQ    (NUM_REQ),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk_50M  (clk_50M),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .grant    (grant),
      .byte_ack (byte_ack),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_done  (tx_done),
      .busy     (busy)
   );

   always #10 clk_50M = ~clk_50M;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Producer model: one message per requester, optionally repeated.
   logic [7:0] mbyte [NUM_REQ][8];
   int         mlen  [NUM_REQ];
   int         mpos  [NUM_REQ];
   int         mrep  [NUM_REQ];
   bit         model_drive;
   // uart_tx model and logs
   bit         uart_auto;
   int         lat;
   int         dcnt;
   int         cyc;
   int         last_done_cyc;
   int         n_start;
   int         n_ack [NUM_REQ];
   logic [NUM_REQ-1:0] prev_grant;
   logic [7:0]         start_data[$];
   logic [NUM_REQ-1:0] start_grant[$];
   logic [NUM_REQ-1:0] rise_grant[$];
   int                 rise_cyc[$];
   int                 fall_cyc[$];
   int                 start_after_done[$];

   task automatic drive_req();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (mpos[i] < mlen[i]) begin
            req[i]              = 1'b1;
            req_data[8*i +: 8]  = mbyte[i][mpos[i]];
            req_last[i]         = (mpos[i] == mlen[i] - 1);
         end else begin
            req[i]              = 1'b0;
            req_data[8*i +: 8]  = 8'h00;
            req_last[i]         = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_50M);
      #1;
      cyc++;
      tx_done = 1'b0;
      if (tx_start) begin
         n_start++;
         start_data.push_back(tx_data);
         start_grant.push_back(grant);
         if (last_done_cyc >= 0) start_after_done.push_back(cyc - last_done_cyc);
         last_done_cyc = -1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (byte_ack[i]) begin
            n_ack[i]++;
            if (mpos[i] < mlen[i]) mpos[i]++;
            if (mpos[i] == mlen[i] && mrep[i] > 0) begin
               mrep[i]--;
               mpos[i] = 0;
            end
         end
      end
      if (grant != prev_grant) begin
         if (grant != '0) begin
            rise_grant.push_back(grant);
            rise_cyc.push_back(cyc);
         end else begin
            fall_cyc.push_back(cyc);
         end
      end
      prev_grant = grant;
      if (uart_auto) begin
         if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
               tx_done       = 1'b1;
               last_done_cyc = cyc;
            end
         end
         if (tx_start) dcnt = lat;
      end
      if (model_drive) drive_req();
   endtask

   task automatic clear_logs();
      n_start = 0;
      for (int i = 0; i < NUM_REQ; i++) n_ack[i] = 0;
      start_data.delete();
      start_grant.delete();
      rise_grant.delete();
      rise_cyc.delete();
      fall_cyc.delete();
      start_after_done.delete();
      last_done_cyc = -1;
      dcnt          = 0;
      prev_grant    = grant;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         mlen[i] = 0;
         mpos[i] = 0;
         mrep[i] = 0;
      end
      req      = '0;
      req_data = '0;
      req_last = '0;
      tx_done  = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic load(input int r, input int n, input int rep,
                       input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      mbyte[r][0] = b0;
      mbyte[r][1] = b1;
      mbyte[r][2] = b2;
      mlen[r]     = n;
      mpos[r]     = 0;
      mrep[r]     = rep;
      drive_req();
   endtask

   task automatic run_quiet(input string name, input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(req == '0 && !busy) && n < budget);
      check({name, "_timeout"}, 32'(n >= budget), 32'd0);
   endtask

   task automatic wait_starts(input string name, input int cnt, input int budget);
      int n;
      n = 0;
      while (n_start < cnt && n < budget) begin
         tick();
         n++;
      end
      check({name, "_timeout"}, 32'(n >= budget), 32'd0);
   endtask

   typedef struct {
      logic               rst_n;
      logic [NUM_REQ-1:0] req;
      logic [NUM_REQ-1:0] last;
      logic [23:0]        data;
      logic               done;
      logic [NUM_REQ-1:0] e_grant;
      logic [NUM_REQ-1:0] e_ack;
      logic               e_start;
      logic [7:0]         e_data;
      logic               e_busy;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, input logic [2:0] q, input logic [2:0] l, input logic [23:0] d,
                      input logic dn, input logic [2:0] eg, input logic [2:0] ea, input logic es,
                      input logic [7:0] ed, input logic eb);
      vec_t v;
      v = '{r, q, l, d, dn, eg, ea, es, ed, eb};
      vt.push_back(v);
   endtask

   logic [7:0] end_data;
   int         bad;

   initial begin
      rst_n       = 1'b0;
      req         = '0;
      req_data    = '0;
      req_last    = '0;
      tx_done     = 1'b0;
      model_drive = 1'b0;
      uart_auto   = 1'b0;
      lat         = 1;
      cyc         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mlen[i] = 0;
         mpos[i] = 0;
         mrep[i] = 0;
      end
      clear_logs();

      // ---- cycle table: reset, then a 1-byte message from requester 2 ----
      add(0, 3'b000, 3'b000, 24'h000000, 0, 3'b000, 3'b000, 0, 8'h00, 0);
      add(1, 3'b000, 3'b000, 24'h000000, 0, 3'b000, 3'b000, 0, 8'h00, 0);
      add(1, 3'b100, 3'b100, 24'hA51122, 0, 3'b100, 3'b100, 1, 8'hA5, 1);
      add(1, 3'b100, 3'b100, 24'hA51122, 1, 3'b100, 3'b000, 0, 8'hA5, 1);
      add(1, 3'b100, 3'b100, 24'hA51122, 0, 3'b100, 3'b000, 0, 8'hA5, 1);
`ifdef UART_TERM_EN
      add(1, 3'b100, 3'b100, 24'hA51122, 1, 3'b100, 3'b000, 1, 8'h23, 1);
      add(1, 3'b000, 3'b000, 24'h000000, 0, 3'b100, 3'b000, 0, 8'h23, 1);
      add(1, 3'b000, 3'b000, 24'h000000, 1, 3'b000, 3'b000, 0, 8'h23, 1);
      end_data = 8'h23;
`else
      add(1, 3'b100, 3'b100, 24'hA51122, 1, 3'b000, 3'b000, 0, 8'hA5, 1);
      end_data = 8'hA5;
`endif
      add(1, 3'b000, 3'b000, 24'h000000, 0, 3'b000, 3'b000, 0, end_data, 1);

      foreach (vt[i]) begin
         rst_n    = vt[i].rst_n;
         req      = vt[i].req;
         req_last = vt[i].last;
         req_data = vt[i].data;
         tx_done  = vt[i].done;
         tick();
         check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(vt[i].e_grant));
         check($sformatf("tbl%0d_ack", i), 32'(byte_ack), 32'(vt[i].e_ack));
         check($sformatf("tbl%0d_start", i), 32'(tx_start), 32'(vt[i].e_start));
         check($sformatf("tbl%0d_data", i), 32'(tx_data), 32'(vt[i].e_data));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      end
      // GAP was entered two rows back; busy holds for the rest of the 16 cycles
      for (int i = 0; i < int'(GAP_CYCLES) - 2; i++) tick();
      check("gap_busy_last_cycle", 32'(busy), 32'd1);
      tick();
      check("gap_busy_released", 32'(busy), 32'd0);

      // ---- single message from requester 1 ----
      model_drive = 1'b1;
      uart_auto   = 1'b1;
      do_reset();
      lat = 100;
      load(1, 2, 0, 8'h41, 8'h42, 8'h00);
      run_quiet("single", 2000);
      check("single_nstart", 32'(n_start), 32'(2 + TE));
      check("single_data0", 32'(start_data[0]), 32'h41);
      check("single_data1", 32'(start_data[1]), 32'h42);
`ifdef UART_TERM_EN
      check("single_term", 32'(start_data[2]), 32'h23);
`endif
      check("single_ack1", 32'(n_ack[1]), 32'd2);
      check("single_ack_other", 32'(n_ack[0] + n_ack[2]), 32'd0);
      bad = 0;
      foreach (start_grant[i]) if (start_grant[i] !== 3'b010) bad++;
      check("single_grant_owner", 32'(bad), 32'd0);
      check("single_grant_rises", 32'(rise_grant.size()), 32'd1);
      check("single_grant_val", 32'(rise_grant[0]), 32'(3'b010));
      check("single_next_byte_lat", 32'(start_after_done[0]), 32'd1);
      check("single_idle_grant", 32'(grant), 32'd0);
      check("single_idle_busy", 32'(busy), 32'd0);

      // ---- round robin, all three requesting, two messages each ----
      do_reset();
      lat = 3;
      for (int i = 0; i < NUM_REQ; i++) load(i, 1, 1, 8'hA0 + 8'(i), 8'h00, 8'h00);
      run_quiet("rr", 2000);
      check("rr_rises", 32'(rise_grant.size()), 32'd6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rr_grant%0d", k), 32'(rise_grant[k]), 32'(3'b001 << (k % 3)));
         check($sformatf("rr_data%0d", k), 32'(start_data[k * (1 + TE)]), 32'(8'hA0 + 8'(k % 3)));
      end
      for (int k = 1; k < 6; k++)
         check($sformatf("rr_gap%0d", k), 32'(rise_cyc[k] - fall_cyc[k-1]), 32'(GAP_CYCLES + 1));

      // ---- requester 2 arrives while requester 0 is mid-message ----
      do_reset();
      lat = 20;
      load(0, 3, 0, 8'h10, 8'h11, 8'h12);
      wait_starts("hold_mid", 2, 500);
      load(2, 1, 0, 8'h77, 8'h00, 8'h00);
      run_quiet("hold", 2000);
      check("hold_rises", 32'(rise_grant.size()), 32'd2);
      check("hold_first", 32'(rise_grant[0]), 32'(3'b001));
      check("hold_second", 32'(rise_grant[1]), 32'(3'b100));
      check("hold_ack0", 32'(n_ack[0]), 32'd3);
      check("hold_ack2", 32'(n_ack[2]), 32'd1);
      check("hold_data2", 32'(start_data[2]), 32'h12);
      check("hold_data_next", 32'(start_data[3 + TE]), 32'h77);
      check("hold_gap", 32'(rise_cyc[1] - fall_cyc[0]), 32'(GAP_CYCLES + 1));

      // ---- abort after the first byte ----
      do_reset();
      lat = 10;
      load(0, 3, 0, 8'h30, 8'h31, 8'h32);
      wait_starts("abort_first", 1, 500);
      mlen[0] = mpos[0];
      drive_req();
      run_quiet("abort", 500);
      check("abort_nstart", 32'(n_start), 32'd1);
      check("abort_ack0", 32'(n_ack[0]), 32'd1);
      check("abort_grant", 32'(grant), 32'd0);
      check("abort_gap_len", 32'(cyc - fall_cyc[0]), 32'(GAP_CYCLES));
      load(0, 1, 0, 8'h40, 8'h00, 8'h00);
      load(2, 1, 0, 8'h42, 8'h00, 8'h00);
      run_quiet("abort_ptr", 2000);
      check("abort_ptr_next", 32'(rise_grant[1]), 32'(3'b100));
      check("abort_ptr_wrap", 32'(rise_grant[2]), 32'(3'b001));

`ifdef UART_TERM_EN
      // ---- terminator after a one-byte message ----
      do_reset();
      lat = 5;
      load(0, 1, 0, 8'h53, 8'h00, 8'h00);
      run_quiet("term", 500);
      check("term_nstart", 32'(n_start), 32'd2);
      check("term_data0", 32'(start_data[0]), 32'h53);
      check("term_data1", 32'(start_data[1]), 32'h23);
      check("term_ack", 32'(n_ack[0]), 32'd1);
`endif

      // ---- reset during WAIT_DONE, late tx_done ignored ----
      do_reset();
      uart_auto = 1'b0;
      load(1, 1, 0, 8'h55, 8'h00, 8'h00);
      wait_starts("rst_start", 1, 50);
      tick();
      rst_n = 1'b0;
      tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_ack", 32'(byte_ack), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
      check("rst_start", 32'(tx_start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n   = 1'b1;
      tx_done = 1'b1;
      tick();
      check("rst_done_start", 32'(tx_start), 32'd0);
      check("rst_done_busy", 32'(busy), 32'd0);
      tick();
      tick();
      check("rst_done_nstart", 32'(n_start), 32'd1);
      check("rst_done_grant", 32'(grant), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
